// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [REG_W-1:0] rd_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [XLEN-1:0]  result_o;
  logic [REG_W-1:0] rd_o;

  modport master (
    output start_i, op_i, a_i, b_i, rd_i, flush_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, rd_i, flush_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, sign fix-up at the end, RISC-V corner cases early-out.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1,
  parameter int REG_W     = 5
) (
  input logic     clk_i,
  input logic     reset_i,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [2:0]        op_q, op_d;
  logic [REG_W-1:0]  rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;

  logic signed [XLEN-1:0] a_s, b_s;
  logic              a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, mul_zero, spec_in;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  // Operand preparation at accept: magnitudes, result sign and corner cases
  always_comb begin
    a_s      = bus.a_i;
    b_s      = bus.b_i;
    a_sgn    = (bus.op_i == 3'd1) || (bus.op_i == 3'd2) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    b_sgn    = (bus.op_i == 3'd1) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    a_neg    = a_sgn && (a_s < 0);
    b_neg    = b_sgn && (b_s < 0);
    a_abs    = a_neg ? -bus.a_i : bus.a_i;
    b_abs    = b_neg ? -bus.b_i : bus.b_i;
    neg_in   = (bus.op_i[2] && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = bus.op_i[2] && (bus.b_i == '0);
    div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.a_i == MIN_INT) && (bus.b_i == ONES);
    mul_zero = !bus.op_i[2] && ((bus.a_i == '0) || (bus.b_i == '0));
    spec_in  = div_zero || div_ovf || mul_zero;
    spec_val = '0;
    if (div_zero)     spec_val = bus.op_i[1] ? bus.a_i : ONES;
    else if (div_ovf) spec_val = bus.op_i[1] ? '0 : MIN_INT;
  end

  // One iteration step (multiply: add-and-shift; divide: restoring trial subtract)
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opb_q};
    if (!op_q[2])
      step = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_diff[XLEN])
      step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection in FIX
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:       fix_res = prod[XLEN-1:0];
      3'd4, 3'd5: fix_res = quo;
      3'd6, 3'd7: fix_res = rem;
      default:    fix_res = prod[2*XLEN-1:XLEN];
    endcase
    if (spec_q) fix_res = spec_res_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    rd_d       = rd_q;
    op_d       = op_q;
    rd_pend_d  = rd_pend_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d       = bus.op_i;
          rd_pend_d  = bus.rd_i;
          opb_d      = b_abs;
          acc_d      = {{XLEN{1'b0}}, a_abs};
          neg_d      = neg_in;
          spec_d     = spec_in;
          spec_res_d = spec_val;
          cnt_d      = CW'(XLEN - 1);
          if (EARLY_OUT && spec_in) begin
            state_d  = S_DONE;
            result_d = spec_val;
            rd_d     = bus.rd_i;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        result_d = fix_res;
        rd_d     = rd_pend_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  // Control and visible result registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // Internal datapath registers, no reset needed
  always_ff @(posedge clk_i) begin
    op_q       <= op_d;
    rd_pend_q  <= rd_pend_d;
    opb_q      <= opb_d;
    acc_q      <= acc_d;
    neg_q      <= neg_d;
    spec_q     <= spec_d;
    spec_res_q <= spec_res_d;
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE) && !bus.flush_i;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32 and XLEN=64 instances).
module tb_muldiv_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(32), .REG_W(5)) m32 ();
  muldiv_if #(.XLEN(64), .REG_W(5)) m64 ();

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1), .REG_W(5)) dut32 (
    .clk_i(clk), .reset_i(reset), .bus(m32.slave));
  muldiv_unit #(.XLEN(64), .EARLY_OUT(1'b1), .REG_W(5)) dut64 (
    .clk_i(clk), .reset_i(reset), .bus(m64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op on the 32-bit unit, then wait for done and check latency/result/rd.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input string tag);
    int n;
    m32.start_i = 1'b1;
    m32.op_i    = op;
    m32.a_i     = a;
    m32.b_i     = b;
    m32.rd_i    = rd;
    tick();
    m32.start_i = 1'b0;
    m32.a_i     = ~a;
    m32.b_i     = ~b;
    m32.rd_i    = ~rd;
    n = 1;
    while (!m32.done_o && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, 64'(m32.result_o), 64'(exp));
    check({tag, "_rd"},  64'(m32.rd_o), 64'(rd));
    tick();
    check({tag, "_idle"}, {62'd0, m32.busy_o, m32.done_o}, 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] held;

    m32.start_i = 0; m32.op_i = 0; m32.a_i = 0; m32.b_i = 0; m32.rd_i = 0; m32.flush_i = 0;
    m64.start_i = 0; m64.op_i = 0; m64.a_i = 0; m64.b_i = 0; m64.rd_i = 0; m64.flush_i = 0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy",   64'(m32.busy_o),   64'd0);
    check("rst_done",   64'(m32.done_o),   64'd0);
    check("rst_result", 64'(m32.result_o), 64'd0);
    check("rst_rd",     64'(m32.rd_o),     64'd0);
    reset = 1'b0;
    tick();

    // Multiply family
    run32(3'd0, 32'hFFFF_FFFF, 32'd3, 5'd1, 32'hFFFF_FFFD, 34, "mul");
    run32(3'd1, 32'hFFFF_FFFF, 32'd3, 5'd2, 32'hFFFF_FFFF, 34, "mulh");
    run32(3'd3, 32'hFFFF_FFFF, 32'd3, 5'd3, 32'h0000_0002, 34, "mulhu");
    run32(3'd2, 32'hFFFF_FFFF, 32'd3, 5'd4, 32'hFFFF_FFFF, 34, "mulhsu");

    // Divide family
    run32(3'd4, 32'hFFFF_FFF9, 32'd2,  5'd5,  32'hFFFF_FFFD, 34, "div");
    run32(3'd6, 32'hFFFF_FFF9, 32'd2,  5'd6,  32'hFFFF_FFFF, 34, "rem");
    run32(3'd5, 32'd100,       32'd7,  5'd7,  32'd14,        34, "divu");
    run32(3'd7, 32'd100,       32'd7,  5'd8,  32'd2,         34, "remu");

    // Early-out corner cases
    run32(3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1, "div0");
    run32(3'd7, 32'h1234,      32'd0,         5'd10, 32'h1234,      1, "remu0");
    run32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, "divovf");
    run32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,         1, "removf");
    run32(3'd1, 32'd0,         32'hDEAD_BEEF, 5'd13, 32'h0,         1, "mulz");
    run32(3'd5, 32'd1000,      32'd10,        5'd14, 32'd100,       34, "divu2");

    // Reset mid-CALC
    m32.start_i = 1'b1; m32.op_i = 3'd5; m32.a_i = 32'd100; m32.b_i = 32'd7; m32.rd_i = 5'd15;
    tick();
    m32.start_i = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy",   64'(m32.busy_o),   64'd0);
    check("rstmid_done",   64'(m32.done_o),   64'd0);
    check("rstmid_result", 64'(m32.result_o), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m32.done_o) pulses++;
    end
    check("rstmid_nodone", 64'(pulses), 64'd0);

    // Establish a known result, then flush mid-op
    run32(3'd5, 32'd50, 32'd5, 5'd16, 32'd10, 34, "pre");
    held = m32.result_o;
    m32.start_i = 1'b1; m32.op_i = 3'd4; m32.a_i = 32'd100; m32.b_i = 32'd7; m32.rd_i = 5'd17;
    tick();
    m32.start_i = 1'b0;
    repeat (4) tick();
    m32.flush_i = 1'b1;
    tick();
    m32.flush_i = 1'b0;
    check("flush_busy",   64'(m32.busy_o),   64'd0);
    check("flush_result", 64'(m32.result_o), 64'(held));
    check("flush_rd",     64'(m32.rd_o),     64'd16);
    run32(3'd5, 32'd1000, 32'd10, 5'd18, 32'd100, 34, "postflush");

    // Start with flush in IDLE is ignored
    m32.start_i = 1'b1; m32.flush_i = 1'b1; m32.op_i = 3'd0; m32.a_i = 32'd2; m32.b_i = 32'd2;
    tick();
    m32.start_i = 1'b0; m32.flush_i = 1'b0;
    check("startflush_busy", 64'(m32.busy_o), 64'd0);

    // Second start during CALC ignored
    m32.start_i = 1'b1; m32.op_i = 3'd0; m32.a_i = 32'd5; m32.b_i = 32'd6; m32.rd_i = 5'd19;
    tick();
    m32.start_i = 1'b0;
    n = 0;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 3) begin
        m32.start_i = 1'b1; m32.a_i = 32'd9; m32.b_i = 32'd9; m32.rd_i = 5'd20;
      end
      if (c == 4) m32.start_i = 1'b0;
      if (m32.done_o) begin
        pulses++;
        if (n == 0) begin
          n = c;
          check("busy2_res", 64'(m32.result_o), 64'd30);
          check("busy2_rd",  64'(m32.rd_o),     64'd19);
        end
      end
      tick();
    end
    check("busy2_pulses", 64'(pulses), 64'd1);
    check("busy2_lat",    64'(n),      64'd34);

    // XLEN=64 MULHU 2^63 * 4
    m64.start_i = 1'b1; m64.op_i = 3'd3; m64.a_i = 64'h8000_0000_0000_0000; m64.b_i = 64'd4; m64.rd_i = 5'd21;
    tick();
    m64.start_i = 1'b0;
    n = 1;
    while (!m64.done_o && n < 200) begin
      tick();
      n++;
    end
    check("mulhu64_lat", 64'(n), 64'd66);
    check("mulhu64_res", m64.result_o, 64'd2);
    check("mulhu64_rd",  64'(m64.rd_o), 64'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit that runs beside the single-cycle ALU in the execute stage of the 5-stage pipeline.
- Accepts one operation per start pulse and holds busy_o for the multi-cycle computation; the hazard unit turns busy_o into stall_f/stall_d/stall_e.
- Returns the result with its destination register for the M stage. It is the parametrised, multi-cycle successor to the fixed 32-bit single-cycle execute datapath.

Parameters:
XLEN, 32, operand/result width (32 or 64)
EARLY_OUT, 1, when 1, divide-by-zero, signed overflow and zero-operand multiply complete in 1 cycle
REG_W, 5, destination register index width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
start_i  in  1  request; sampled only in IDLE
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  in  XLEN  rs1 operand (after forwarding)
b_i  in  XLEN  rs2 operand (after forwarding)
rd_i  in  REG_W  destination register
flush_i  in  1  cancel in-flight operation (branch mispredict / flush_e)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse: result_o/rd_o valid
result_o  out  XLEN  result; held until next accepted start
rd_o  out  REG_W  destination of result_o; held with result_o

Behaviour:
- Reset, synchronous: state IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0, counter=0. Reset wins over every other input, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start_i=1 and flush_i=0, latch op, rd, operands and sign flags, then go to CALC.
  - On start_i=1 and flush_i=1, ignore the request and stay in IDLE.
- Operand prep at accept:
  - Signed ops take the absolute value of signed operands. MULHSU treats only a as signed.
  - Record neg_res. For MUL* it is the XOR of the operand signs. For DIV it is sign(a) XOR sign(b). For REM it is sign(a).
- CALC, multiply: shift-add, one multiplier bit per cycle into a 2*XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC runs exactly XLEN cycles. The counter counts XLEN-1 down to 0, then the unit goes to FIX.
- FIX:
  - Negate the product, quotient or remainder if neg_res.
  - Select the output: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register the result into result_o, then go to DONE.
- DONE: done_o=1 for this single cycle, then go to IDLE. busy_o=1 in DONE; start_i is not sampled in DONE.
- Latency: start accepted at edge 0 gives done_o high during cycle XLEN+2 (34 for XLEN=32). busy_o is high for cycles 1..XLEN+2.
- Special cases when EARLY_OUT=1: the unit goes IDLE to DONE directly, so done_o is high in cycle 1. The results follow the RISC-V spec:
  - b=0, DIV/DIVU: all ones.
  - b=0, REM/REMU: a.
  - DIV with a=MIN_INT, b=-1: MIN_INT.
  - REM with a=MIN_INT, b=-1: 0.
  - MUL* with a=0 or b=0: 0.
- When EARLY_OUT=0, these cases take the full latency with identical results.
- flush_i in CALC, FIX or DONE: next state is IDLE. done_o is forced to 0 in the flush cycle and the next cycle. result_o and rd_o keep their previous values.
- result_o and rd_o update only on the FIX-to-DONE edge or the early-out edge.
- Operand inputs may change after accept without effect.
- No back-pressure: the consumer must take the result on done_o.

Test Plan:
- Reset mid-CALC: start DIVU a=100 b=7, assert reset_i at cycle 10 -> next cycle busy_o=0, done_o=0, result_o=0; no done_o pulse follows.
- MUL and MULH: start MUL a=0xFFFF_FFFF (-1) b=3 -> done_o in cycle 34 with result 0xFFFF_FFFD. MULH with the same operands -> 0xFFFF_FFFF. MULHU -> 0x0000_0002.
- DIV and REM: a=-7 b=2 -> DIV 0xFFFF_FFFD (-3), REM 0xFFFF_FFFF (-1). DIVU a=100 b=7 -> 14, with rd_o equal to rd_i at accept.
- Divide by zero and overflow, EARLY_OUT=1: DIV x/0 -> 0xFFFF_FFFF at cycle 1. REMU 0x1234/0 -> 0x1234. DIV 0x8000_0000/-1 -> 0x8000_0000. REM of the same -> 0.
- Flush mid-op: start DIV, assert flush_i at cycle 5 -> busy_o=0 at cycle 6, no done_o pulse, result_o unchanged. A new start at cycle 6 completes normally at cycle 6+34.
- Start while busy and XLEN=64: a second start_i during CALC is ignored, so only one done_o pulse occurs. With XLEN=64, MULHU 2^63 * 4 -> 2, with done_o in cycle 66.
